// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time toward an async-read, sync-write data memory.
// Define LSU_SUBWORD_EN to build byte/halfword loads and read-modify-write stores.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  output logic                  Req_Ready_o,
  input  logic                  Req_Write_i,
  input  logic [2:0]            Req_Funct3_i,
  input  logic [DATA_WIDTH-1:0] Req_Address_i,
  input  logic [DATA_WIDTH-1:0] Req_Write_Data_i,
  output logic                  Resp_Valid_o,
  output logic [DATA_WIDTH-1:0] Resp_Data_o,
  output logic                  Access_Error_o,
  output logic                  Mem_Read_o,
  output logic                  Mem_Write_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, DONE, ERR
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            f3_q;
  logic                  write_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic                  err_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  req_legal;
  logic [DATA_WIDTH-1:0] load_data_d;

  // Legality of the incoming request: funct3 decode plus natural alignment.
  always_comb begin
    req_legal = 1'b0;
`ifdef LSU_SUBWORD_EN
    unique case (Req_Funct3_i)
      3'b000:         req_legal = 1'b1;
      3'b001:         req_legal = ~Req_Address_i[0];
      3'b010:         req_legal = (Req_Address_i[1:0] == 2'b00);
      3'b100, 3'b101: req_legal = ~Req_Write_i & ~(Req_Funct3_i[0] & Req_Address_i[0]);
      default:        req_legal = 1'b0;
    endcase
`else
    req_legal = (Req_Funct3_i == 3'b010) && (Req_Address_i[1:0] == 2'b00);
`endif
  end

`ifdef LSU_SUBWORD_EN
  logic [BYTE_W-1:0]     ld_byte;
  logic [HALF_W-1:0]     ld_half;
  logic [DATA_WIDTH-1:0] merge_d;

  // Lane extraction with sign/zero extension, and lane merge for RMW stores.
  always_comb begin
    ld_byte = Mem_Read_Data_i[{addr_q[1:0], 3'b000} +: BYTE_W];
    ld_half = Mem_Read_Data_i[{addr_q[1], 4'b0000} +: HALF_W];
    unique case (f3_q[1:0])
      2'b00:   load_data_d = {{(DATA_WIDTH-BYTE_W){ld_byte[BYTE_W-1] & ~f3_q[2]}}, ld_byte};
      2'b01:   load_data_d = {{(DATA_WIDTH-HALF_W){ld_half[HALF_W-1] & ~f3_q[2]}}, ld_half};
      default: load_data_d = Mem_Read_Data_i;
    endcase
    merge_d = Mem_Read_Data_i;
    if (f3_q[0]) merge_d[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
    else         merge_d[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
  end
`else
  always_comb begin
    load_data_d = (f3_q == 3'b010) ? Mem_Read_Data_i : '0;
  end
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      write_q      <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_data_q  <= '0;
      mem_wdata_q  <= '0;
    end else begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (Req_Valid_i) begin
            ready_q <= 1'b0;
            addr_q  <= Req_Address_i;
            wdata_q <= Req_Write_Data_i;
            f3_q    <= Req_Funct3_i;
            write_q <= Req_Write_i;
            if (!req_legal) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              resp_data_q  <= '0;
            end else if (Req_Write_i) begin
`ifdef LSU_SUBWORD_EN
              if (Req_Funct3_i != 3'b010) begin
                state_q <= RMW_RD;
                rd_q    <= 1'b1;
              end else
`endif
              begin
                state_q     <= STORE_W;
                wr_q        <= 1'b1;
                mem_wdata_q <= Req_Write_Data_i;
              end
            end else begin
              state_q <= LOAD;
              rd_q    <= 1'b1;
            end
          end
        end
        LOAD: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          resp_data_q  <= load_data_d;
        end
        STORE_W: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          resp_data_q  <= '0;
        end
`ifdef LSU_SUBWORD_EN
        RMW_RD: begin
          state_q     <= RMW_WR;
          wr_q        <= 1'b1;
          mem_wdata_q <= merge_d;
        end
        RMW_WR: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          resp_data_q  <= '0;
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are masked by reset so an aborted access never commits.
  assign Mem_Read_o       = rd_q & ~reset;
  assign Mem_Write_o      = wr_q & ~reset & write_q;
  assign Mem_Address_o    = addr_q;
  assign Mem_Write_Data_o = mem_wdata_q;
  assign Req_Ready_o      = ready_q;
  assign Resp_Valid_o     = resp_valid_q;
  assign Resp_Data_o      = resp_data_q;
  assign Access_Error_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  localparam int unsigned DW = 32;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          Req_Valid_i, Req_Ready_o, Req_Write_i;
  logic [2:0]    Req_Funct3_i;
  logic [DW-1:0] Req_Address_i, Req_Write_Data_i;
  logic          Resp_Valid_o, Access_Error_o, Mem_Read_o, Mem_Write_o;
  logic [DW-1:0] Resp_Data_o, Mem_Address_o, Mem_Write_Data_o, Mem_Read_Data_i;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .Req_Valid_i(Req_Valid_i), .Req_Ready_o(Req_Ready_o), .Req_Write_i(Req_Write_i),
    .Req_Funct3_i(Req_Funct3_i), .Req_Address_i(Req_Address_i),
    .Req_Write_Data_i(Req_Write_Data_i), .Resp_Valid_o(Resp_Valid_o),
    .Resp_Data_o(Resp_Data_o), .Access_Error_o(Access_Error_o),
    .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .Mem_Address_o(Mem_Address_o),
    .Mem_Write_Data_o(Mem_Write_Data_o), .Mem_Read_Data_i(Mem_Read_Data_i)
  );

  always #5 clk = ~clk;

  // Memory model: gated async read, sync write, preload port for setup.
  logic [DW-1:0] mem [16];
  logic          pl_en = 1'b0;
  logic [3:0]    pl_idx = '0;
  logic [DW-1:0] pl_data = '0;
  assign Mem_Read_Data_i = Mem_Read_o ? mem[Mem_Address_o[5:2]] : '0;

  int            rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
  logic [DW-1:0] last_wdata = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (Mem_Write_o) mem[Mem_Address_o[5:2]] <= Mem_Write_Data_o;
    if (Mem_Read_o) rd_cnt <= rd_cnt + 1;
    if (Mem_Write_o) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= Mem_Write_Data_o;
    end
    if (Mem_Read_o && Mem_Write_o) both_cnt <= both_cnt + 1;
    if (Resp_Valid_o) resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic present(input logic wr, input logic [2:0] f3, input logic [DW-1:0] a,
                         input logic [DW-1:0] d);
    Req_Valid_i = 1'b1; Req_Write_i = wr; Req_Funct3_i = f3;
    Req_Address_i = a; Req_Write_Data_i = d;
  endtask

  // One request end to end: latency, response, error flag and memory strobe counts.
  task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                     input logic [DW-1:0] a, input logic [DW-1:0] d, input int exp_lat,
                     input logic [DW-1:0] exp_data, input logic exp_err,
                     input int exp_rd, input int exp_wr);
    int rd0, wr0, lat;
    logic [DW-1:0] rdata;
    logic aerr;
    @(negedge clk);
    check({tag, "/ready"}, DW'(Req_Ready_o), DW'(1));
    rd0 = rd_cnt; wr0 = wr_cnt;
    present(wr, f3, a, d);
    @(posedge clk);
    #1 Req_Valid_i = 1'b0;
    lat = 0; rdata = '0; aerr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (Resp_Valid_o) begin
        lat = i; rdata = Resp_Data_o; aerr = Access_Error_o;
        break;
      end
    end
    check({tag, "/latency"}, DW'(lat), DW'(exp_lat));
    check({tag, "/data"}, rdata, exp_data);
    check({tag, "/err"}, DW'(aerr), DW'(exp_err));
    check({tag, "/reads"}, DW'(rd_cnt - rd0), DW'(exp_rd));
    check({tag, "/writes"}, DW'(wr_cnt - wr0), DW'(exp_wr));
    @(negedge clk);
    check({tag, "/pulse"}, DW'(Resp_Valid_o), DW'(0));
  endtask

  initial begin
    int wr0, rd0, rs0;
    reset = 1'b1;
    Req_Valid_i = 1'b0; Req_Write_i = 1'b0; Req_Funct3_i = '0;
    Req_Address_i = '0; Req_Write_Data_i = '0;
    preload(4'd4, 32'h8899AABB);
    preload(4'd8, 32'h0000_0000);
    preload(4'd9, 32'h1122_3344);
    @(negedge clk);
    check("rst/ready", DW'(Req_Ready_o), DW'(1));
    check("rst/resp", DW'(Resp_Valid_o), DW'(0));
    check("rst/err", DW'(Access_Error_o), DW'(0));
    check("rst/strobes", DW'({Mem_Read_o, Mem_Write_o}), DW'(0));
    check("rst/addr", Mem_Address_o, DW'(0));
    check("rst/rdata", Resp_Data_o, DW'(0));
    check("rst/wdata", Mem_Write_Data_o, DW'(0));
    reset = 1'b0;

    // Sub-word loads from 0x8899AABB at 0x10.
    txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, SUB ? 2 : 1, SUB ? 32'hFFFFFF88 : 32'h0, !SUB, SUB ? 1 : 0, 0);
    check("lb13/hold", Resp_Data_o, SUB ? 32'hFFFFFF88 : 32'h0);
    txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, SUB ? 2 : 1, SUB ? 32'h00000088 : 32'h0, !SUB, SUB ? 1 : 0, 0);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, SUB ? 2 : 1, SUB ? 32'h00008899 : 32'h0, !SUB, SUB ? 1 : 0, 0);
    txn("lh10", 1'b0, 3'b001, 32'h10, 32'h0, SUB ? 2 : 1, SUB ? 32'hFFFFAABB : 32'h0, !SUB, SUB ? 1 : 0, 0);

    // Byte store via read-modify-write, then read back.
    txn("sb11", 1'b1, 3'b000, 32'h11, 32'h123456CC, SUB ? 3 : 1, 32'h0, !SUB, SUB ? 1 : 0, SUB ? 1 : 0);
    check("sb11/mem", mem[4], SUB ? 32'h8899CCBB : 32'h8899AABB);
    txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, SUB ? 32'h8899CCBB : 32'h8899AABB, 1'b0, 1, 0);

    // Held store request: single write, ready low for two cycles, store response data zero.
    @(negedge clk);
    wr0 = wr_cnt;
    present(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    check("swhold/ready1", DW'(Req_Ready_o), DW'(0));
    check("swhold/wstrobe", DW'(Mem_Write_o), DW'(1));
    @(negedge clk);
    check("swhold/ready2", DW'(Req_Ready_o), DW'(0));
    check("swhold/resp", DW'(Resp_Valid_o), DW'(1));
    check("swhold/rdata", Resp_Data_o, DW'(0));
    @(posedge clk);
    #1 Req_Valid_i = 1'b0;
    @(negedge clk);
    check("swhold/ready3", DW'(Req_Ready_o), DW'(1));
    repeat (2) @(negedge clk);
    check("swhold/writes", DW'(wr_cnt - wr0), DW'(1));
    check("swhold/wdata", last_wdata, 32'hDEADBEEF);
    check("swhold/mem", mem[8], 32'hDEADBEEF);

    // Load held across its own busy window is accepted again once ready returns.
    @(negedge clk);
    rd0 = rd_cnt;
    present(1'b0, 3'b010, 32'h20, 32'h0);
    repeat (4) @(posedge clk);
    #1 Req_Valid_i = 1'b0;
    @(negedge clk);
    check("reacc/rstrobe", DW'(Mem_Read_o), DW'(1));
    check("reacc/ready", DW'(Req_Ready_o), DW'(0));
    repeat (3) @(negedge clk);
    check("reacc/reads", DW'(rd_cnt - rd0), DW'(2));
    check("reacc/rdata", Resp_Data_o, 32'hDEADBEEF);

    // Misaligned and illegal-funct3 requests.
    txn("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("sh13", 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 1, 32'h0, 1'b1, 0, 0);
    txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("st100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    check("err/mem", mem[4], SUB ? 32'h8899CCBB : 32'h8899AABB);

    // Reset during the write cycle of a word store.
    @(negedge clk);
    wr0 = wr_cnt; rs0 = resp_cnt;
    present(1'b1, 3'b010, 32'h24, 32'hCAFEF00D);
    @(posedge clk);
    #1 Req_Valid_i = 1'b0;
    @(negedge clk);
    check("rstsw/wstrobe", DW'(Mem_Write_o), DW'(1));
    reset = 1'b1;
    #1 check("rstsw/gated", DW'(Mem_Write_o), DW'(0));
    @(negedge clk);
    reset = 1'b0;
    check("rstsw/ready0", DW'(Req_Ready_o), DW'(1));
    @(negedge clk);
    check("rstsw/ready1", DW'(Req_Ready_o), DW'(1));
    repeat (3) @(negedge clk);
    check("rstsw/writes", DW'(wr_cnt - wr0), DW'(0));
    check("rstsw/resp", DW'(resp_cnt - rs0), DW'(0));
    check("rstsw/mem", mem[9], 32'h11223344);

`ifdef LSU_SUBWORD_EN
    // Reset during the read half of a halfword RMW.
    @(negedge clk);
    wr0 = wr_cnt; rs0 = resp_cnt;
    present(1'b1, 3'b001, 32'h22, 32'h00005555);
    @(posedge clk);
    #1 Req_Valid_i = 1'b0;
    @(negedge clk);
    check("rstsh/rstrobe", DW'(Mem_Read_o), DW'(1));
    reset = 1'b1;
    #1 check("rstsh/gated", DW'(Mem_Read_o), DW'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstsh/ready", DW'(Req_Ready_o), DW'(1));
    repeat (3) @(negedge clk);
    check("rstsh/writes", DW'(wr_cnt - wr0), DW'(0));
    check("rstsh/resp", DW'(resp_cnt - rs0), DW'(0));
    check("rstsh/mem", mem[8], 32'hDEADBEEF);
`endif

    check("overlap", DW'(both_cnt), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
